tile_map_renderer: RTL and testbench
====================================

Name: tile_map_renderer

Overview:
- Consumer side of the 20x15 tile map: stores one 4-bit tile id per 32x32-pixel tile of the 640x480 screen and converts the VGA controller's h_cnt/v_cnt/valid stream into 12-bit RGB.
- Game logic writes tiles through a valid/ready port.
- A 16-entry palette maps tile id to colour.
- Sits between vga_controller and the board's vgaRed/vgaGreen/vgaBlue/hsync/vsync pins; runs entirely on the 25 MHz pixel clock.

Parameters:
- FILL_TILE, 1, tile id written to every cell by reset and by clear.
- COLS, 20, tiles per row (fixed 32-pixel tile width).
- ROWS, 15, tile rows (fixed 32-pixel tile height).

Ports:
- pclk  in  1  25 MHz pixel clock; all logic on rising edge.
- rst  in  1  Reset; synchronous, active-high.
- h_cnt  in  10  Pixel column from vga_controller.
- v_cnt  in  10  Pixel row from vga_controller.
- valid  in  1  Active-video flag from vga_controller.
- hsync_i  in  1  Raw hsync.
- vsync_i  in  1  Raw vsync.
- wr_valid  in  1  Tile write request.
- wr_ready  out  1  Write port can accept.
- wr_x  in  5  Tile column.
- wr_y  in  4  Tile row.
- wr_tile  in  4  Tile id.
- wr_err  out  1  Sticky: an out-of-range write was dropped.
- clr  in  1  Single-cycle pulse; refill map with FILL_TILE.
- busy  out  1  Clear sweep in progress.
- pal_we  in  1  Palette write enable.
- pal_idx  in  4  Palette entry.
- pal_rgb  in  12  {R,G,B} 4 bits each.
- rgb  out  12  Pixel colour {R[11:8],G[7:4],B[3:0]}.
- hsync_o  out  1  hsync delayed to align with rgb.
- vsync_o  out  1  vsync delayed to align with rgb.

Behaviour:
- Storage: 300x4 tile RAM, address = ty*20+tx (9 bits).
  - One synchronous read port for pixel fetch.
  - One write port shared by the write handshake and the clear FSM.
- Pixel pipeline: fixed latency of 3 pclk from h_cnt/v_cnt/valid/hsync_i/vsync_i to rgb/hsync_o/vsync_o.
  - S1: register tx=h_cnt[9:5], ty=v_cnt[8:5], and the computed address. Register pix_ok = valid && h_cnt<640 && v_cnt<480.
  - S2: RAM read returns the tile id.
  - S3: palette lookup, registered to rgb. rgb=12'h000 when pix_ok=0.
  - Syncs pass through a matching 3-stage shift register.
- Palette: 16x12 registers.
  - Reset value of entry k is {k,k,k} (grey ramp).
  - A pal_we write in cycle n affects pixels in S3 at cycle n+1 and later.
- FSM states: CLEAR and IDLE.
  - rst: state=CLEAR, clear address=0, wr_err=0, palette reset, all pipeline registers 0. rgb/hsync_o/vsync_o are 0 for the 3 cycles after reset release.
  - CLEAR: write FILL_TILE to the current address each cycle; address 0..299. After writing 299, go to IDLE the next cycle. The sweep takes exactly 300 cycles. busy=1 and wr_ready=0 throughout.
  - clr asserted during CLEAR restarts the sweep at address 0.
  - IDLE: busy=0, wr_ready=1.
- Write handshake: a write is accepted when wr_valid && wr_ready.
  - The RAM is written in the same edge; the pixel read path sees it from the next cycle.
  - Out-of-range writes (wr_x>=20 or wr_y>=15) are accepted but not written, and set wr_err. wr_err clears only on rst.
  - clr and an accepted write in the same IDLE cycle: the write is performed, then CLEAR starts next cycle and overwrites it.
- Pixel reads during CLEAR return current RAM contents, so the display may show a partially cleared frame.
- rst mid-sweep or mid-frame restarts the full clear at address 0.
- Address arithmetic uses 9 bits; ty*20 is computed as (ty<<4)+(ty<<2). No wrap is possible for legal counts.

Optional Feature:
- Macro GRID_OVERLAY_EN.
- Defined: in S3, any pix_ok pixel whose h_cnt[4:0]==0 or v_cnt[4:0]==0 (values carried down the pipeline) outputs 12'hFFF instead of the palette colour, drawing white tile borders. Latency is unchanged.
- Undefined: no overlay logic; rgb is always the palette colour or black.

Test Plan:
- Reset, then idle → busy=1 for exactly 300 cycles, wr_ready=0 throughout, then busy=0/wr_ready=1. A full frame scan shows every active pixel as rgb=12'h111 (FILL_TILE=1, grey ramp).
- Write (wr_x=3, wr_y=2, wr_tile=5) after clear, with palette[5]=12'hF00 → pixel h_cnt=96..127, v_cnt=64..95 gives rgb=12'hF00 three cycles after the count. The neighbouring pixel h_cnt=128 gives 12'h111.
- valid=0 or h_cnt=700 → rgb=12'h000. hsync_i pulse appears on hsync_o exactly 3 cycles later.
- Write wr_x=20, wr_y=0 → wr_err=1, map unchanged. wr_err stays 1 until rst.
- clr pulse at sweep address 150 → sweep restarts; busy stays high 300 further cycles. A write presented during CLEAR completes only after busy falls.
- GRID_OVERLAY_EN defined → pixels h_cnt=32 on any active line and v_cnt=0 on any column give rgb=12'hFFF. Undefined → same pixels give the palette colour.

Source files
------------

// File: rtl/tile_map_renderer_if.sv
// Tile write port between game logic (master) and tile_map_renderer (slave).
interface tile_map_renderer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_x;
  logic [3:0] wr_y;
  logic [3:0] wr_tile;
  logic       wr_err;

  modport master (output wr_valid, wr_x, wr_y, wr_tile, input wr_ready, wr_err);
  modport slave  (input wr_valid, wr_x, wr_y, wr_tile, output wr_ready, wr_err);
endinterface

// File: rtl/tile_map_renderer.sv
// 20x15 tile map + 16-entry palette turning the VGA h_cnt/v_cnt stream into 12-bit RGB, 3-cycle latency.
// Optional white tile-border overlay when GRID_OVERLAY_EN is defined.
//
//   state | meaning
//   CLEAR | sweeping FILL_TILE into addresses 0..COLS*ROWS-1, write port stalled
//   IDLE  | map stable, write port open
module tile_map_renderer #(
  parameter logic [3:0] FILL_TILE = 4'd1,
  parameter int         COLS      = 20,
  parameter int         ROWS      = 15
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic [9:0]           h_cnt,
  input  logic [9:0]           v_cnt,
  input  logic                 valid,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  tile_map_renderer_if.slave   wr,
  input  logic                 clr,
  output logic                 busy,
  input  logic                 pal_we,
  input  logic [3:0]           pal_idx,
  input  logic [11:0]          pal_rgb,
  output logic [11:0]          rgb,
  output logic                 hsync_o,
  output logic                 vsync_o
);

  localparam int         CELLS = COLS * ROWS;
  localparam logic [8:0] LAST  = 9'(CELLS - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t      state;
  logic [8:0]  clr_addr;
  logic [3:0]  tile_ram [CELLS];
  logic [11:0] pal [16];

  logic        wr_acc, wr_in_range;
  logic [8:0]  wr_addr, pix_addr;
  logic        ram_we;
  logic [8:0]  ram_addr;
  logic [3:0]  ram_din;

  logic [8:0]  s1_addr;
  logic        s1_ok, s2_ok;
  logic [1:0]  s1_sync, s2_sync;
  logic [3:0]  s2_tile;
  logic [11:0] px_col;

  assign wr_acc      = wr.wr_valid && wr.wr_ready;
  assign wr_in_range = (wr.wr_x < 5'(COLS)) && (wr.wr_y < 4'(ROWS));

  // Row stride of 20 done as (y<<4)+(y<<2) to keep the adder tiny.
  assign wr_addr  = ({5'd0, wr.wr_y} << 4) + ({5'd0, wr.wr_y} << 2) + {4'd0, wr.wr_x};
  assign pix_addr = ({5'd0, v_cnt[8:5]} << 4) + ({5'd0, v_cnt[8:5]} << 2) + {4'd0, h_cnt[9:5]};

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = wr_addr;
    ram_din  = wr.wr_tile;
    if (!rst) begin
      if (state == CLEAR) begin
        ram_we   = 1'b1;
        ram_addr = clr_addr;
        ram_din  = FILL_TILE;
      end else if (wr_acc && wr_in_range) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (ram_we) tile_ram[ram_addr] <= ram_din;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_addr    <= 9'd0;
      busy        <= 1'b1;
      wr.wr_ready <= 1'b0;
      wr.wr_err   <= 1'b0;
    end else begin
      if (wr_acc && !wr_in_range) wr.wr_err <= 1'b1;
      case (state)
        CLEAR: begin
          if (clr) begin
            clr_addr <= 9'd0;
          end else if (clr_addr == LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            wr.wr_ready <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 9'd1;
          end
        end
        IDLE: begin
          // A write accepted alongside clr still lands; the sweep then overwrites it.
          if (clr) begin
            state       <= CLEAR;
            clr_addr    <= 9'd0;
            busy        <= 1'b1;
            wr.wr_ready <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) pal[k] <= {3{4'(k)}};
    end else if (pal_we) begin
      pal[pal_idx] <= pal_rgb;
    end
  end

`ifdef GRID_OVERLAY_EN
  logic s1_grid, s2_grid;

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_grid <= 1'b0;
      s2_grid <= 1'b0;
    end else begin
      s1_grid <= (h_cnt[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0);
      s2_grid <= s1_grid;
    end
  end

  assign px_col = s2_grid ? 12'hFFF : pal[s2_tile];
`else
  assign px_col = pal[s2_tile];
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_addr <= 9'd0;
      s1_ok   <= 1'b0;
      s1_sync <= 2'b00;
      s2_ok   <= 1'b0;
      s2_tile <= 4'd0;
      s2_sync <= 2'b00;
      rgb     <= 12'h000;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else begin
      s1_addr <= pix_addr;
      s1_ok   <= valid && (h_cnt < 10'(COLS * 32)) && (v_cnt < 10'(ROWS * 32));
      s1_sync <= {hsync_i, vsync_i};
      s2_ok   <= s1_ok;
      // Only in-range addresses index the RAM; off-screen pixels are blanked anyway.
      if (s1_ok) s2_tile <= tile_ram[s1_addr];
      s2_sync <= s1_sync;
      rgb     <= s2_ok ? px_col : 12'h000;
      hsync_o <= s2_sync[1];
      vsync_o <= s2_sync[0];
    end
  end

endmodule

// File: tb/tb_tile_map_renderer.sv
// Scoreboarded bench for tile_map_renderer: pixel expectations queued at drive time, checked 3 cycles later.
module tb_tile_map_renderer;

`ifdef GRID_OVERLAY_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid, hsync_i, vsync_i;
  logic        clr, busy, pal_we;
  logic [3:0]  pal_idx;
  logic [11:0] pal_rgb, rgb;
  logic        hsync_o, vsync_o;

  tile_map_renderer_if wif ();

  tile_map_renderer dut (
    .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .wr(wif), .clr(clr), .busy(busy),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb), .rgb(rgb),
    .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #20 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  always @(negedge pclk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        total_cnt++;
        $display("FAIL pix_stale: entry due %0d seen at %0d", e.due, cyc);
      end else if (e.chk) begin
        total_cnt++;
        if (rgb === e.rgb && hsync_o === e.hs && vsync_o === e.vs) pass_cnt++;
        else $display("FAIL pix@%0d: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                      cyc, rgb, hsync_o, vsync_o, e.rgb, e.hs, e.vs);
      end
    end
  end

  task automatic pix(input int h, input int v, input bit vl, input bit hs, input bit vs,
                     input logic [11:0] er);
    @(posedge pclk); #1;
    h_cnt = 10'(h); v_cnt = 10'(v); valid = vl; hsync_i = hs; vsync_i = vs;
    sb.push_back('{due: cyc + 3, rgb: er, hs: hs, vs: vs, chk: 1'b1});
  endtask

  task automatic pal_wr(input logic [3:0] idx, input logic [11:0] c);
    @(posedge pclk); #1;
    pal_we = 1'b1; pal_idx = idx; pal_rgb = c;
    @(posedge pclk); #1;
    pal_we = 1'b0;
  endtask

  task automatic wr(input int x, input int y, input int t, output bit ok);
    @(posedge pclk); #1;
    wif.wr_valid = 1'b1; wif.wr_x = 5'(x); wif.wr_y = 4'(y); wif.wr_tile = 4'(t);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge pclk);
      if (wif.wr_ready) begin
        @(posedge pclk);
        ok = 1'b1;
        break;
      end
    end
    #1 wif.wr_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    bit ok;
    rst = 1'b1; h_cnt = '0; v_cnt = '0; valid = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    clr = 1'b0; pal_we = 1'b0; pal_idx = '0; pal_rgb = '0;
    wif.wr_valid = 1'b0; wif.wr_x = '0; wif.wr_y = '0; wif.wr_tile = '0;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_hsync", int'(hsync_o), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_wr_ready", int'(wif.wr_ready), 0);
    chk("rst_wr_err", int'(wif.wr_err), 0);

    @(posedge pclk); #1 rst = 1'b0;
    n = 0; bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge pclk);
      if (!busy) break;
      n++;
      if (wif.wr_ready) bad++;
    end
    chk("init_busy_cycles", n, 300);
    chk("init_ready_low_cycles", bad, 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_wr_ready", int'(wif.wr_ready), 1);

    // Sample every tile of the freshly filled map.
    for (int ty = 0; ty < 15; ty++)
      for (int tx = 0; tx < 20; tx++)
        pix(tx * 32 + 7, ty * 32 + 9, 1'b1, 1'b0, 1'b0, 12'h111);

    pal_wr(4'd5, 12'hF00);
    wr(3, 2, 5, ok);
    chk("wr_accept", int'(ok), 1);
    pix(96, 64, 1'b1, 1'b0, 1'b0, GRID ? 12'hFFF : 12'hF00);
    pix(127, 95, 1'b1, 1'b0, 1'b0, 12'hF00);
    pix(110, 80, 1'b1, 1'b0, 1'b0, 12'hF00);
    pix(128, 70, 1'b1, 1'b0, 1'b0, GRID ? 12'hFFF : 12'h111);
    pix(129, 70, 1'b1, 1'b0, 1'b0, 12'h111);
    pix(95, 70, 1'b1, 1'b0, 1'b0, 12'h111);
    pix(32, 100, 1'b1, 1'b0, 1'b0, GRID ? 12'hFFF : 12'h111);
    pix(200, 0, 1'b1, 1'b0, 1'b0, GRID ? 12'hFFF : 12'h111);
    pix(100, 70, 1'b0, 1'b0, 1'b0, 12'h000);
    pix(700, 70, 1'b1, 1'b0, 1'b0, 12'h000);
    pix(100, 480, 1'b1, 1'b0, 1'b0, 12'h000);

    // Sync pulses must come out exactly 3 cycles later; neighbours check they are not early/late.
    pix(300, 200, 1'b1, 1'b0, 1'b0, 12'h111);
    pix(301, 200, 1'b1, 1'b1, 1'b0, 12'h111);
    pix(302, 200, 1'b1, 1'b0, 1'b0, 12'h111);
    pix(303, 200, 1'b1, 1'b0, 1'b1, 12'h111);
    pix(304, 200, 1'b1, 1'b0, 1'b0, 12'h111);
    pix(305, 200, 1'b1, 1'b0, 1'b0, 12'h111);

    // Palette write in the 4th stream cycle: first two pixels keep the old colour.
    for (int i = 0; i < 8; i++) begin
      pix(100, 70, 1'b1, 1'b0, 1'b0, (i < 2) ? 12'hF00 : 12'h0F0);
      if (i == 3) begin pal_we = 1'b1; pal_idx = 4'd5; pal_rgb = 12'h0F0; end
      if (i == 4) pal_we = 1'b0;
    end

    wr(20, 0, 7, ok);
    chk("oor_accept", int'(ok), 1);
    @(negedge pclk);
    chk("oor_wr_err", int'(wif.wr_err), 1);
    pix(5, 40, 1'b1, 1'b0, 1'b0, 12'h111);
    pix(5, 5, 1'b1, 1'b0, 1'b0, 12'h111);
    repeat (5) @(posedge pclk);
    @(negedge pclk);
    chk("wr_err_sticky", int'(wif.wr_err), 1);

    // clr from IDLE, then a second clr at sweep address 150 with a write pending.
    @(posedge pclk); #1 clr = 1'b1;
    @(posedge pclk); #1 clr = 1'b0;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge pclk);
      if (!busy) bad++;
    end
    chk("clr_first_half_busy", bad, 0);
    @(posedge pclk); #1;
    clr = 1'b1;
    wif.wr_valid = 1'b1; wif.wr_x = 5'd3; wif.wr_y = 4'd2; wif.wr_tile = 4'd9;
    @(posedge pclk); #1 clr = 1'b0;
    n = 0; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge pclk);
      if (!busy) break;
      n++;
      if (wif.wr_ready) bad++;
    end
    chk("clr_restart_busy", n, 300);
    chk("clr_ready_low", bad, 0);
    chk("clr_then_ready", int'(wif.wr_ready), 1);
    @(posedge pclk); #1 wif.wr_valid = 1'b0;
    chk("clr_keeps_wr_err", int'(wif.wr_err), 1);
    pix(100, 70, 1'b1, 1'b0, 1'b0, 12'h999);
    pix(140, 70, 1'b1, 1'b0, 1'b0, 12'h111);
    pix(5, 40, 1'b1, 1'b0, 1'b0, 12'h111);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge pclk);
    @(negedge pclk);
    if (sb.size() > 0) begin
      total_cnt++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    @(posedge pclk); #1 rst = 1'b1;
    @(posedge pclk); #1 rst = 1'b0;
    @(negedge pclk);
    chk("rst_clears_wr_err", int'(wif.wr_err), 0);
    chk("rst_restarts_clear", int'(busy), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
